// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: grants one of N requesters the shared sequence-detector datapath in rotating priority.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD granted cycles and pulse timeout.
module round_robin_arbiter #(
  parameter int N = 4,
  parameter int MAX_HOLD = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  done,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id,
  output logic          busy,
  output logic          timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  if (N < 1 || N > 16 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_cfg
    $error("round_robin_arbiter: N or MAX_HOLD out of range");
  end
  state_t state;
  logic [IW-1:0] ptr;
  logic [IW:0] arb;
  logic hit_done, keep, rel;
  // {found, index} of the first requester at or after p, wrapping
  function automatic logic [IW:0] pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic [IW:0] res;
    logic [IW-1:0] j;
    res = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = IW'((int'(p) + i) % N);
      if (r[j]) res = {1'b1, j};
    end
    return res;
  endfunction
  assign arb = pick(req, ptr);
  assign hit_done = |(grant & done);
  assign keep = |(grant & req);
`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold;
  logic expire;
  assign expire = hold == 8'(MAX_HOLD - 1);
  assign rel = hit_done | ~keep | expire;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      hold <= 8'd0;
      timeout <= 1'b0;
    end else begin
      hold <= (state == GRANT) ? hold + 8'd1 : 8'd0;
      timeout <= (state == GRANT) & expire & ~hit_done & keep;
    end
`else
  assign rel = hit_done | ~keep;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      grant_id <= '0;
      busy <= 1'b0;
      ptr <= '0;
    end else if (state == GRANT) begin
      if (rel) begin
        state <= RELEASE;
        grant <= '0;
        grant_id <= '0;
        busy <= 1'b0;
        ptr <= (int'(grant_id) == N - 1) ? '0 : grant_id + 1'b1;
      end
    end else if (arb[IW]) begin
      state <= GRANT;
      grant <= N'(1) << arb[IW-1:0];
      grant_id <= arb[IW-1:0];
      busy <= 1'b1;
    end else begin
      state <= IDLE;
    end
endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb_round_robin_arbiter: directed and randomized checks of round_robin_arbiter against a behavioural model.
module tb_round_robin_arbiter;
  localparam int N = 4;
  localparam int MAX_HOLD = 8;
  localparam int IW = 2;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] done = '0;
  logic [N-1:0] grant;
  logic [IW-1:0] grant_id;
  logic busy, timeout;
  int checks = 0;
  int errors = 0;
  int m_cur = -1;
  int m_ptr = 0;
  int m_hold = 0;
  bit m_to = 1'b0;

  round_robin_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .done(done),
    .grant(grant), .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = -1;
    m_ptr = 0;
    m_hold = 0;
    m_to = 1'b0;
  endtask

  // One clock edge of the arbitration rules: owner keeps the grant until done/withdraw/limit, else rotate.
  task automatic model_step();
    logic [N-1:0] oh;
    m_to = 1'b0;
    if (m_cur >= 0) begin
      oh = N'(1) << m_cur;
      if ((done & oh) != 0 || (req & oh) == 0 || (TO_EN && m_hold == MAX_HOLD)) begin
        m_to = (done & oh) == 0 && (req & oh) != 0;
        m_ptr = (m_cur + 1) % N;
        m_cur = -1;
      end else m_hold++;
    end else begin
      for (int k = 0; k < N; k++) begin
        oh = N'(1) << ((m_ptr + k) % N);
        if (m_cur < 0 && (req & oh) != 0) begin
          m_cur = (m_ptr + k) % N;
          m_hold = 1;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("grant", 32'(grant), (m_cur < 0) ? 32'd0 : (32'd1 << m_cur));
    chk("grant_id", 32'(grant_id), (m_cur < 0) ? 32'd0 : 32'(m_cur));
    chk("busy", 32'(busy), 32'(m_cur >= 0));
    chk("timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] d);
    req = r;
    done = d;
    @(posedge clock);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r, d;
    r = '0;
    #3;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    cyc(4'b0000, 4'b0000);
    chk("idle", 32'(grant), 32'd0);
    cyc(4'b0100, 4'b0000);
    chk("first_grant", 32'(grant), 32'b0100);
    chk("first_id", 32'(grant_id), 32'd2);
    chk("first_busy", 32'(busy), 32'd1);
    cyc(4'b0100, 4'b0100);
    chk("done_release", 32'(grant), 32'd0);
    cyc(4'b0100, 4'b0000);
    chk("gap_one_cycle", 32'(grant), 32'b0100);
    cyc(4'b0100, 4'b0100);
    cyc(4'b0011, 4'b0000);
    chk("wrap_to_0", 32'(grant), 32'b0001);
    cyc(4'b0011, 4'b0001);
    cyc(4'b0011, 4'b0000);
    chk("then_1", 32'(grant), 32'b0010);
    cyc(4'b0011, 4'b1001);
    chk("ignore_other_done", 32'(grant), 32'b0010);
    cyc(4'b0011, 4'b0000);
    cyc(4'b0001, 4'b1001);
    chk("withdraw_release", 32'(grant), 32'd0);
    cyc(4'b0001, 4'b0000);
    cyc(4'b1000, 4'b0001);
    cyc(4'b1000, 4'b0000);
    chk("pre_reset_grant", 32'(grant), 32'b1000);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_timeout", 32'(timeout), 32'd0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    cyc(4'b1010, 4'b0000);
    chk("ptr_cleared", 32'(grant), 32'b0010);
    do_reset();
    for (int g = 0; g < 5; g++) begin
      cyc(4'b1111, 4'b0000);
      chk("fair_c1", 32'(grant), 32'd1 << (g % N));
      cyc(4'b1111, 4'b0000);
      chk("fair_c2", 32'(grant), 32'd1 << (g % N));
      cyc(4'b1111, 4'b0000);
      chk("fair_c3", 32'(grant), 32'd1 << (g % N));
      cyc(4'b1111, 4'(1 << (g % N)));
      chk("fair_gap", 32'(grant), 32'd0);
    end
    do_reset();
    cyc(4'b0001, 4'b0000);
    for (int k = 2; k <= MAX_HOLD; k++) begin
      cyc(4'b0001, 4'b0000);
      chk("hold", 32'(grant), 32'b0001);
    end
    cyc(4'b0001, 4'b0000);
    chk("limit_grant", 32'(grant), TO_EN ? 32'd0 : 32'b0001);
    chk("limit_timeout", 32'(timeout), 32'(TO_EN));
    cyc(4'b0001, 4'b0000);
    chk("timeout_pulse", 32'(timeout), 32'd0);
    do_reset();
    cyc(4'b0001, 4'b0000);
    for (int k = 2; k < MAX_HOLD; k++) cyc(4'b0001, 4'b0000);
    cyc(4'b0001, 4'b0001);
    chk("done_at_limit", 32'(grant), 32'd0);
    chk("done_no_timeout", 32'(timeout), 32'd0);
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      d = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
      cyc(r, d);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
